// File: rtl/nf10_axis_rr_arbiter_if.sv
// AXI4-Stream bundle carrying N_LANES packed streams; master drives payload, slave drives ready.
interface nf10_axis_rr_arbiter_if #(
  parameter int N_LANES     = 1,
  parameter int DATA_WIDTH  = 64,
  parameter int TUSER_WIDTH = 128
);
  logic [N_LANES*DATA_WIDTH-1:0]   tdata;
  logic [N_LANES*DATA_WIDTH/8-1:0] tstrb;
  logic [N_LANES*TUSER_WIDTH-1:0]  tuser;
  logic [N_LANES-1:0]              tvalid;
  logic [N_LANES-1:0]              tready;
  logic [N_LANES-1:0]              tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_rr_arbiter.sv
// Packet-level round-robin arbiter: C_NUM_PORTS AXI4-Stream inputs onto one output, grant held to tlast.
// Optional macro ARB_SRC_PORT_TAG_EN stamps the one-hot source port into m_axis tuser[23:16].
module nf10_axis_rr_arbiter #(
  parameter int C_NUM_PORTS        = 4,
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_MAX_PKT_BEATS    = 256
) (
  input  logic                     aclk,
  input  logic                     areset,
  nf10_axis_rr_arbiter_if.slave    s_axis,
  nf10_axis_rr_arbiter_if.master   m_axis,
  output logic [C_NUM_PORTS-1:0]   arb_grant,
  output logic                     pkt_done,
  output logic                     err_long_pkt
);

  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(C_NUM_PORTS);
  localparam int CNT_W  = $clog2(C_MAX_PKT_BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(C_MAX_PKT_BEATS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(C_NUM_PORTS - 1);

  generate
    if (C_NUM_PORTS < 2 || C_NUM_PORTS > 8) begin : g_badPorts
      $error("nf10_axis_rr_arbiter: C_NUM_PORTS must be 2..8");
    end
`ifdef ARB_SRC_PORT_TAG_EN
    if (C_AXIS_TUSER_WIDTH < 24) begin : g_badUser
      $error("nf10_axis_rr_arbiter: source tag needs C_AXIS_TUSER_WIDTH >= 24");
    end
`endif
  endgenerate

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [IDX_W-1:0]        r_grantIdx;
  logic [IDX_W-1:0]        r_lastIdx;
  logic [CNT_W-1:0]        r_beatCnt;
  logic                    r_pktDone;
  logic                    r_errLong;

  logic [C_NUM_PORTS-1:0]        w_arbGrant;
  logic [C_NUM_PORTS-1:0]        w_sReady;
  logic [C_AXIS_DATA_WIDTH-1:0]  w_tdata;
  logic [STRB_W-1:0]             w_tstrb;
  logic [C_AXIS_TUSER_WIDTH-1:0] w_tuser;
  logic [C_AXIS_TUSER_WIDTH-1:0] w_tuserOut;
  logic                          w_tvalid;
  logic                          w_tlast;
  logic                          w_xfer;
  logic                          w_lastXfer;

  // First valid port after the previous winner, wrapping modulo C_NUM_PORTS.
  function automatic logic [IDX_W-1:0] f_nextIdx(input logic [IDX_W-1:0] last,
                                                 input logic [C_NUM_PORTS-1:0] valid);
    int   idx;
    logic found;
    f_nextIdx = last;
    found     = 1'b0;
    for (int k = 1; k <= C_NUM_PORTS; k++) begin
      idx = int'(last) + k;
      if (idx >= C_NUM_PORTS) idx = idx - C_NUM_PORTS;
      if (!found && valid[IDX_W'(idx)]) begin
        found     = 1'b1;
        f_nextIdx = IDX_W'(idx);
      end
    end
  endfunction

  always_comb begin
    w_arbGrant = '0;
    w_sReady   = '0;
    w_tdata    = '0;
    w_tstrb    = '0;
    w_tuser    = '0;
    w_tvalid   = 1'b0;
    w_tlast    = 1'b0;
    if (r_state == ST_PKT) begin
      for (int i = 0; i < C_NUM_PORTS; i++) begin
        if (r_grantIdx == IDX_W'(i)) begin
          w_arbGrant[i] = 1'b1;
          w_sReady[i]   = m_axis.tready;
          w_tdata       = s_axis.tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
          w_tstrb       = s_axis.tstrb[i*STRB_W +: STRB_W];
          w_tuser       = s_axis.tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
          w_tvalid      = s_axis.tvalid[i];
          w_tlast       = s_axis.tlast[i];
        end
      end
    end
    w_tuserOut = w_tuser;
`ifdef ARB_SRC_PORT_TAG_EN
    w_tuserOut[23:16] = 8'(w_arbGrant);
`endif
  end

  assign w_xfer     = w_tvalid & m_axis.tready;
  assign w_lastXfer = w_xfer & w_tlast;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (|s_axis.tvalid) w_stateNext = ST_PKT;
      ST_PKT:  if (w_lastXfer)     w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  // Beat counter saturates at all-ones, which always lies above CNT_LIMIT.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_grantIdx <= '0;
      r_lastIdx  <= IDX_LAST;
      r_beatCnt  <= '0;
      r_pktDone  <= 1'b0;
      r_errLong  <= 1'b0;
    end else begin
      r_pktDone <= w_lastXfer;
      if (r_state == ST_IDLE && |s_axis.tvalid)
        r_grantIdx <= f_nextIdx(r_lastIdx, s_axis.tvalid);
      if (w_lastXfer) begin
        r_lastIdx <= r_grantIdx;
        r_beatCnt <= '0;
      end else if (w_xfer && r_beatCnt != '1) begin
        r_beatCnt <= r_beatCnt + 1'b1;
      end
      if (C_MAX_PKT_BEATS != 0 && w_xfer && !w_tlast && r_beatCnt == CNT_LIMIT)
        r_errLong <= 1'b1;
    end
  end

  assign s_axis.tready = w_sReady;
  assign m_axis.tdata  = w_tdata;
  assign m_axis.tstrb  = w_tstrb;
  assign m_axis.tuser  = w_tuserOut;
  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tlast  = w_tlast;
  assign arb_grant     = w_arbGrant;
  assign pkt_done      = r_pktDone;
  assign err_long_pkt  = r_errLong;

endmodule
